zkbdmus_loader: RTL and testbench

- Producer side of the keyboard/mouse path: takes command-framed bytes from the slave SPI byte engine and assembles them into the 40-bit key matrix and the mouse/kempston bytes.
- Issues one-cycle load strobes toward the port-side keyboard/mouse mux, which latches the data.
- Sits between the slave SPI block and the Z80 port mux, in the fclk domain.

---
 rtl/zkbdmus_loader.sv | 110 +++++++++++
 tb/tb_zkbdmus_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/zkbdmus_loader.sv
// Assembles command-framed SPI bytes into the 40-bit key matrix and mouse/joystick
// bytes, issuing one-cycle registered load strobes toward the port-side mux.
module zkbdmus_loader #(
   parameter logic [7:0] CMD_KBD    = 8'h10,
   parameter logic [7:0] CMD_MUSX   = 8'h20,
   parameter logic [7:0] CMD_MUSY   = 8'h21,
   parameter logic [7:0] CMD_MUSBTN = 8'h22,
   parameter logic [7:0] CMD_KJ     = 8'h23
) (
   input  logic        fclk,
   input  logic        rst,
   input  logic        spi_start,
   input  logic [7:0]  spi_cmd,
   input  logic        spi_stb,
   input  logic [7:0]  spi_byte,
   input  logic        spi_end,
   output logic [39:0] kbd_out,
   output logic        kbd_stb,
   output logic [7:0]  mus_out,
   output logic        mus_xstb,
   output logic        mus_ystb,
   output logic        mus_btnstb,
   output logic        kj_stb
);

   typedef enum logic [1:0] {IDLE, KBD, MUS, SKIP} state_t;
   typedef enum logic [1:0] {T_X, T_Y, T_BTN, T_KJ} target_t;

   state_t      state_reg;
   target_t     target_reg;
   logic [2:0]  count_reg;
   logic [39:0] shadow_reg;
   logic [5:0]  byte_base;

   assign byte_base = {count_reg, 3'b000};

   always_ff @(posedge fclk) begin
      if (rst) begin
         state_reg  <= IDLE;
         target_reg <= T_X;
         count_reg  <= 3'd0;
         shadow_reg <= 40'd0;
         kbd_out    <= 40'd0;
         mus_out    <= 8'd0;
         kbd_stb    <= 1'b0;
         mus_xstb   <= 1'b0;
         mus_ystb   <= 1'b0;
         mus_btnstb <= 1'b0;
         kj_stb     <= 1'b0;
      end else begin
         kbd_stb    <= 1'b0;
         mus_xstb   <= 1'b0;
         mus_ystb   <= 1'b0;
         mus_btnstb <= 1'b0;
         kj_stb     <= 1'b0;

         // A new command aborts whatever is in flight; a byte arriving with it is dropped.
         if (spi_start) begin
            count_reg <= 3'd0;
            if (spi_cmd == CMD_KBD) begin
               state_reg <= KBD;
            end else if (spi_cmd == CMD_MUSX) begin
               state_reg  <= MUS;
               target_reg <= T_X;
            end else if (spi_cmd == CMD_MUSY) begin
               state_reg  <= MUS;
               target_reg <= T_Y;
            end else if (spi_cmd == CMD_MUSBTN) begin
               state_reg  <= MUS;
               target_reg <= T_BTN;
            end else if (spi_cmd == CMD_KJ) begin
               state_reg  <= MUS;
               target_reg <= T_KJ;
            end else begin
               state_reg <= SKIP;
            end
         end else begin
            if (spi_stb) begin
               case (state_reg)
                  KBD: begin
                     shadow_reg[byte_base +: 8] <= spi_byte;
                     count_reg <= count_reg + 3'd1;
                     if (count_reg == 3'd4) begin
                        kbd_out   <= {spi_byte, shadow_reg[31:0]};
                        kbd_stb   <= 1'b1;
                        state_reg <= SKIP;
                     end
                  end
                  MUS: begin
                     mus_out <= spi_byte;
                     case (target_reg)
                        T_X:     mus_xstb   <= 1'b1;
                        T_Y:     mus_ystb   <= 1'b1;
                        T_BTN:   mus_btnstb <= 1'b1;
                        default: kj_stb     <= 1'b1;
                     endcase
                     state_reg <= SKIP;
                  end
                  default: ;
               endcase
            end
            // End of transfer overrides the byte-driven transition but not its strobe.
            if (spi_end) begin
               state_reg <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_zkbdmus_loader.sv
// Directed and randomized bench for zkbdmus_loader against a queue-based command model.
module tb_zkbdmus_loader;

   logic        fclk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_start = 1'b0;
   logic [7:0]  spi_cmd = 8'h00;
   logic        spi_stb = 1'b0;
   logic [7:0]  spi_byte = 8'h00;
   logic        spi_end = 1'b0;
   logic [39:0] kbd_out;
   logic        kbd_stb;
   logic [7:0]  mus_out;
   logic        mus_xstb;
   logic        mus_ystb;
   logic        mus_btnstb;
   logic        kj_stb;

   zkbdmus_loader dut (
      .fclk(fclk), .rst(rst),
      .spi_start(spi_start), .spi_cmd(spi_cmd),
      .spi_stb(spi_stb), .spi_byte(spi_byte), .spi_end(spi_end),
      .kbd_out(kbd_out), .kbd_stb(kbd_stb), .mus_out(mus_out),
      .mus_xstb(mus_xstb), .mus_ystb(mus_ystb),
      .mus_btnstb(mus_btnstb), .kj_stb(kj_stb)
   );

   always #5 fclk = ~fclk;

   // Model: the active command code (0 = nothing collecting) plus bytes received so far.
   logic [7:0]  m_cmd;
   logic [7:0]  m_bytes[$];
   logic [39:0] exp_kbd;
   logic [7:0]  exp_mus;
   logic [4:0]  exp_stb;   // {kbd, x, y, btn, kj}
   int          n_checks = 0;
   int          n_pass = 0;

   function automatic logic [4:0] mus_strobe(input logic [7:0] cmd);
      case (cmd)
         8'h20:   return 5'b01000;
         8'h21:   return 5'b00100;
         8'h22:   return 5'b00010;
         default: return 5'b00001;
      endcase
   endfunction

   task automatic model(input bit r, input bit s, input logic [7:0] c,
                        input bit b, input logic [7:0] d, input bit e);
      exp_stb = 5'b0;
      if (r) begin
         m_cmd = 8'h00;
         m_bytes.delete();
         exp_kbd = 40'h0;
         exp_mus = 8'h0;
      end else if (s) begin
         m_bytes.delete();
         m_cmd = (c == 8'h10 || (c >= 8'h20 && c <= 8'h23)) ? c : 8'h00;
      end else begin
         if (b && m_cmd == 8'h10) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 5) begin
               exp_kbd = {m_bytes[4], m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
               exp_stb = 5'b10000;
               m_cmd = 8'h00;
            end
         end else if (b && m_cmd != 8'h00) begin
            exp_mus = d;
            exp_stb = mus_strobe(m_cmd);
            m_cmd = 8'h00;
         end
         if (e) begin
            m_cmd = 8'h00;
            m_bytes.delete();
         end
      end
   endtask

   task automatic check(input string tag);
      logic [4:0] act_stb;
      act_stb = {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb};
      n_checks++;
      assert (act_stb === exp_stb) n_pass++;
      else $error("FAIL %s strobes: got %b expected %b", tag, act_stb, exp_stb);
      n_checks++;
      assert (kbd_out === exp_kbd) n_pass++;
      else $error("FAIL %s kbd_out: got %h expected %h", tag, kbd_out, exp_kbd);
      n_checks++;
      assert (mus_out === exp_mus) n_pass++;
      else $error("FAIL %s mus_out: got %h expected %h", tag, mus_out, exp_mus);
   endtask

   // One clock cycle: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input string tag, input bit r, input bit s, input logic [7:0] c,
                       input bit b, input logic [7:0] d, input bit e);
      @(negedge fclk);
      rst = r; spi_start = s; spi_cmd = c; spi_stb = b; spi_byte = d; spi_end = e;
      @(posedge fclk);
      #1;
      model(r, s, c, b, d, e);
      check(tag);
      $display("step %-10s rst=%0b start=%0b cmd=%h stb=%0b byte=%h end=%0b -> stb=%b kbd=%h mus=%h",
               tag, r, s, c, b, d, e,
               {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb}, kbd_out, mus_out);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 8'h00, 0, 8'h00, 0);
   endtask

   task automatic start(input string tag, input logic [7:0] c);
      step(tag, 0, 1, c, 0, 8'h00, 0);
   endtask

   task automatic send(input string tag, input logic [7:0] d);
      step(tag, 0, 0, 8'h00, 1, d, 0);
   endtask

   initial begin
      logic [7:0] kb_bytes[5];
      logic [7:0] rc;
      int         sel;
      m_cmd = 8'h00;
      exp_kbd = 40'h0;
      exp_mus = 8'h0;
      exp_stb = 5'b0;
      kb_bytes = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

      step("reset", 1, 0, 8'h00, 0, 8'h00, 0);
      step("reset", 1, 0, 8'h00, 0, 8'h00, 0);
      idle("post_rst");

      start("kbd_start", 8'h10);
      for (int i = 0; i < 5; i++) send("kbd_byte", kb_bytes[i]);
      idle("kbd_hold");
      send("kbd_6th", 8'hAA);
      step("kbd_end", 0, 0, 8'h00, 0, 8'h00, 1);

      start("kbd_part", 8'h10);
      for (int i = 0; i < 3; i++) send("part_byte", 8'h5A);
      step("part_end", 0, 0, 8'h00, 0, 8'h00, 1);
      start("kbd_ff", 8'h10);
      for (int i = 0; i < 4; i++) send("ff_byte", 8'hFF);
      step("ff_last_end", 0, 0, 8'h00, 1, 8'hFF, 1);
      idle("ff_hold");

      start("musy", 8'h21);
      send("musy_byte", 8'h7E);
      send("musy_2nd", 8'h11);
      step("musy_end", 0, 0, 8'h00, 0, 8'h00, 1);

      start("kbd_abort", 8'h10);
      send("abort_b", 8'h33);
      send("abort_b", 8'h44);
      step("kj_start", 0, 1, 8'h23, 1, 8'hEE, 0);
      send("kj_byte", 8'h1F);
      idle("kj_hold");

      start("kbd_rst", 8'h10);
      for (int i = 0; i < 4; i++) send("rst_byte", 8'hC3);
      step("mid_rst", 1, 0, 8'h00, 0, 8'h00, 0);
      send("after_rst", 8'hC3);
      start("unknown", 8'h99);
      send("unk_byte", 8'h12);
      send("unk_byte", 8'h34);
      step("start_end", 0, 1, 8'h22, 0, 8'h00, 1);
      send("btn_byte", 8'h07);
      start("musx", 8'h20);
      step("x_end_same", 0, 0, 8'h00, 1, 8'h80, 1);

      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom_range(0, 5));
         case (sel)
            0: rc = 8'h10;
            1: rc = 8'h20;
            2: rc = 8'h21;
            3: rc = 8'h22;
            4: rc = 8'h23;
            default: rc = 8'($urandom);
         endcase
         step("rand",
              ($urandom_range(0, 79) == 0),
              ($urandom_range(0, 6) == 0), rc,
              ($urandom_range(0, 1) == 1), 8'($urandom),
              ($urandom_range(0, 19) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
